lif_neuron_array: RTL and testbench

- Parametrised, multi-channel successor to the single integrate-and-fire neuron.
- N_CH independent leaky integrate-and-fire (LIF) neurons share one clock, one control set and one runtime configuration.
- Each neuron has signed saturating integration, a per-timestep leak, a selectable post-spike reset mode and a refractory counter.
- Sits between the synapse/crossbar accumulation stage and the spike router. Spikes are emitted once per timestep on a `step` strobe.

---
 rtl/lif_neuron_array.sv | 143 ++++++++++++++
 tb/tb_lif_neuron_array.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_array.sv
// Array of N_CH leaky integrate-and-fire neurons sharing one control/config set.
// Each lane integrates signed input, leaks toward zero and fires on the step strobe.

module lif_lane #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 16,
  parameter int REFRAC_W = 4
) (
  input  logic                clk,
  input  logic                RST,
  input  logic                clken,
  input  logic                clr,
  input  logic                in_valid,
  input  logic                step,
  input  logic                reset_mode,
  input  logic [DATA_W-1:0]   din,
  input  logic [ACC_W-1:0]    threshold,
  input  logic [ACC_W-1:0]    leak,
  input  logic [REFRAC_W-1:0] refrac_len,
  output logic                spike,
  output logic [ACC_W-1:0]    acc
);

  logic [REFRAC_W-1:0]     refrac;
  logic signed [ACC_W:0]   din_x, acc_x, sum_x, v_x, lk_x, vl_x, res_x;
  logic signed [ACC_W-1:0] v, vl, thr;
  logic                    fire, active;

  function automatic logic [ACC_W-1:0] sat(input logic signed [ACC_W:0] x);
    logic signed [ACC_W:0] hi, lo;
    hi = $signed({2'b00, {(ACC_W-1){1'b1}}});
    lo = $signed({2'b11, {(ACC_W-1){1'b0}}});
    if (x > hi)      sat = hi[ACC_W-1:0];
    else if (x < lo) sat = lo[ACC_W-1:0];
    else             sat = x[ACC_W-1:0];
  endfunction

  always_comb begin
    din_x  = {{(ACC_W+1-DATA_W){din[DATA_W-1]}}, din};
    acc_x  = {acc[ACC_W-1], acc};
    sum_x  = in_valid ? acc_x + din_x : acc_x;
    v      = sat(sum_x);
    v_x    = {v[ACC_W-1], v};
    lk_x   = {1'b0, leak};
    vl_x   = v_x;
    vl     = '0;
    // Leak pulls toward zero; a sign change of the extended result means it crossed.
    if (!v[ACC_W-1] && (v != '0)) begin
      vl_x = v_x - lk_x;
      if (!vl_x[ACC_W]) vl = vl_x[ACC_W-1:0];
    end else if (v[ACC_W-1]) begin
      vl_x = v_x + lk_x;
      if (vl_x[ACC_W]) vl = vl_x[ACC_W-1:0];
    end
    thr    = threshold;
    res_x  = {vl[ACC_W-1], vl} - {thr[ACC_W-1], thr};
    fire   = (vl >= thr);
    active = (refrac == '0);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      acc    <= '0;
      refrac <= '0;
      spike  <= 1'b0;
    end else if (clken) begin
      if (clr) begin
        acc    <= '0;
        refrac <= '0;
        spike  <= 1'b0;
      end else if (step) begin
        if (!active) begin
          refrac <= refrac - REFRAC_W'(1);
          spike  <= 1'b0;
        end else if (fire) begin
          spike  <= 1'b1;
          refrac <= refrac_len;
          acc    <= reset_mode ? sat(res_x) : '0;
        end else begin
          spike  <= 1'b0;
          acc    <= vl;
        end
      end else if (in_valid && active) begin
        acc <= v;
      end
    end
  end

endmodule

module lif_neuron_array #(
  parameter int N_CH     = 4,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 16,
  parameter int REFRAC_W = 4
) (
  input  logic                    clk,
  input  logic                    RST,
  input  logic                    clken,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic [N_CH*DATA_W-1:0]  data_in,
  input  logic                    step,
  input  logic [ACC_W-1:0]        threshold,
  input  logic [ACC_W-1:0]        leak,
  input  logic [REFRAC_W-1:0]     refrac_len,
  input  logic                    reset_mode,
  output logic [N_CH-1:0]         spike_out,
  output logic                    spike_valid,
  output logic [N_CH*ACC_W-1:0]   membrane_out
);

  logic [N_CH-1:0][DATA_W-1:0] din;
  logic [N_CH-1:0][ACC_W-1:0]  acc;

  assign din          = data_in;
  assign membrane_out = acc;

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    lif_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W), .REFRAC_W(REFRAC_W)) u_lane (
      .clk        (clk),
      .RST        (RST),
      .clken      (clken),
      .clr        (clr),
      .in_valid   (in_valid),
      .step       (step),
      .reset_mode (reset_mode),
      .din        (din[i]),
      .threshold  (threshold),
      .leak       (leak),
      .refrac_len (refrac_len),
      .spike      (spike_out[i]),
      .acc        (acc[i])
    );
  end

  // Pulse ignores clken so it always drops after one cycle.
  always_ff @(posedge clk) begin
    if (RST) spike_valid <= 1'b0;
    else     spike_valid <= clken & step & ~clr;
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Randomized + directed bench for lif_neuron_array with a queue-based scoreboard
// fed by an integer reference model.

module tb_lif_neuron_array;
  localparam int N_CH = 4, DATA_W = 8, ACC_W = 16, REFRAC_W = 4;
  localparam int MAXA = (1 << (ACC_W-1)) - 1;
  localparam int MINA = -(1 << (ACC_W-1));

  logic                   clk = 1'b0;
  logic                   RST, clken, clr, in_valid, step, reset_mode;
  logic [N_CH*DATA_W-1:0] data_in;
  logic [ACC_W-1:0]       threshold, leak;
  logic [REFRAC_W-1:0]    refrac_len;
  logic [N_CH-1:0]        spike_out;
  logic                   spike_valid;
  logic [N_CH*ACC_W-1:0]  membrane_out;

  lif_neuron_array #(.N_CH(N_CH), .DATA_W(DATA_W), .ACC_W(ACC_W), .REFRAC_W(REFRAC_W)) dut (
    .clk(clk), .RST(RST), .clken(clken), .clr(clr), .in_valid(in_valid),
    .data_in(data_in), .step(step), .threshold(threshold), .leak(leak),
    .refrac_len(refrac_len), .reset_mode(reset_mode), .spike_out(spike_out),
    .spike_valid(spike_valid), .membrane_out(membrane_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                  sv;
    logic [N_CH-1:0]       spk;
    logic [N_CH*ACC_W-1:0] mem;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0, n_fail = 0;

  logic signed [DATA_W-1:0] d [N_CH];
  int m_acc [N_CH];
  int m_ref [N_CH];
  bit m_spk [N_CH];
  bit m_sv;

  function automatic int clamp(int x);
    if (x > MAXA) return MAXA;
    if (x < MINA) return MINA;
    return x;
  endfunction

  function automatic int macc(int i);
    logic signed [ACC_W-1:0] t;
    t = membrane_out[i*ACC_W +: ACC_W];
    return int'(t);
  endfunction

  task automatic chk(string nm, int got, int expv);
    n_tests++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, expv);
    end
  endtask

  // Reference model advanced by one clock edge from the current inputs.
  task automatic cyc();
    exp_t e;
    int dv, v, vl, thr, lk;
    for (int i = 0; i < N_CH; i++) data_in[i*DATA_W +: DATA_W] = d[i];
    thr = int'($signed(threshold));
    lk  = int'(leak);
    if (RST) begin
      for (int i = 0; i < N_CH; i++) begin m_acc[i] = 0; m_ref[i] = 0; m_spk[i] = 0; end
      m_sv = 0;
    end else begin
      m_sv = clken && step && !clr;
      if (clken) begin
        for (int i = 0; i < N_CH; i++) begin
          dv = in_valid ? int'(d[i]) : 0;
          if (clr) begin
            m_acc[i] = 0; m_ref[i] = 0; m_spk[i] = 0;
          end else if (step) begin
            if (m_ref[i] != 0) begin
              m_ref[i]--; m_spk[i] = 0;
            end else begin
              v = clamp(m_acc[i] + dv);
              if (v > 0)      vl = (v - lk > 0) ? v - lk : 0;
              else if (v < 0) vl = (v + lk < 0) ? v + lk : 0;
              else            vl = 0;
              if (vl >= thr) begin
                m_spk[i] = 1; m_ref[i] = int'(refrac_len);
                m_acc[i] = reset_mode ? clamp(vl - thr) : 0;
              end else begin
                m_spk[i] = 0; m_acc[i] = vl;
              end
            end
          end else if (in_valid && m_ref[i] == 0) begin
            m_acc[i] = clamp(m_acc[i] + dv);
          end
        end
      end
    end
    e.sv = m_sv;
    for (int i = 0; i < N_CH; i++) begin
      e.spk[i] = m_spk[i];
      e.mem[i*ACC_W +: ACC_W] = ACC_W'(m_acc[i]);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented output cycle is checked against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_tests++;
      if (spike_valid !== e.sv || membrane_out !== e.mem || (spike_out !== e.spk)) begin
        n_fail++;
        $display("FAIL scoreboard: spike_valid %b/%b spike_out %b/%b membrane %h/%h (got/exp)",
                 spike_valid, e.sv, spike_out, e.spk, membrane_out, e.mem);
      end
    end
  end

  task automatic zero_d();
    for (int i = 0; i < N_CH; i++) d[i] = '0;
  endtask

  task automatic do_clr();
    in_valid = 0; step = 0; clr = 1; cyc(); clr = 0;
  endtask

  initial begin
    RST = 1; clken = 1; clr = 0; step = 0; in_valid = 1; reset_mode = 0;
    threshold = 16'd20; leak = '0; refrac_len = '0;
    for (int i = 0; i < N_CH; i++) d[i] = 8'sd5;

    // Reset and hold
    cyc(); cyc();
    chk("rst_acc0", macc(0), 0);
    chk("rst_spike", int'(spike_out), 0);
    chk("rst_valid", int'(spike_valid), 0);
    RST = 0; clken = 0; cyc(); cyc();
    chk("hold_acc0", macc(0), 0);
    clken = 1;

    // Integrate and fire, zero reset
    do_clr(); zero_d();
    d[0] = 8'sd7; d[1] = 8'sd3; in_valid = 1;
    repeat (3) cyc();
    in_valid = 0; step = 1; cyc(); step = 0;
    chk("fire_spk0", int'(spike_out[0]), 1);
    chk("fire_spk1", int'(spike_out[1]), 0);
    chk("fire_valid", int'(spike_valid), 1);
    chk("fire_acc0", macc(0), 0);
    chk("fire_acc1", macc(1), 9);
    cyc();
    chk("valid_pulse_end", int'(spike_valid), 0);
    chk("spike_hold", int'(spike_out[0]), 1);

    // Subtract mode with leak
    do_clr(); zero_d();
    threshold = 16'd10; leak = 16'd2; reset_mode = 1;
    d[0] = 8'sd25; in_valid = 1; cyc(); in_valid = 0;
    step = 1;
    cyc(); chk("sub_acc_a", macc(0), 13); chk("sub_spk_a", int'(spike_out[0]), 1);
    cyc(); chk("sub_acc_b", macc(0), 1);  chk("sub_spk_b", int'(spike_out[0]), 1);
    cyc(); chk("sub_acc_c", macc(0), 0);  chk("sub_spk_c", int'(spike_out[0]), 0);
    step = 0;

    // Refractory
    do_clr(); zero_d();
    threshold = 16'd5; leak = '0; reset_mode = 0; refrac_len = 4'd2;
    d[0] = 8'sd10; in_valid = 1; step = 1;
    cyc(); chk("ref_fire1", int'(spike_out[0]), 1);
    cyc(); chk("ref_quiet1", int'(spike_out[0]), 0); chk("ref_acc1", macc(0), 0);
    cyc(); chk("ref_quiet2", int'(spike_out[0]), 0); chk("ref_acc2", macc(0), 0);
    cyc(); chk("ref_fire2", int'(spike_out[0]), 1);
    step = 0; refrac_len = '0;

    // Saturation both ways, then negative leak stopping at zero
    do_clr(); zero_d();
    threshold = 16'd100;
    d[0] = 8'sd127; d[1] = -8'sd128; in_valid = 1;
    repeat (300) cyc();
    chk("sat_pos", macc(0), 32767);
    chk("sat_neg", macc(1), -32768);
    do_clr(); zero_d();
    d[0] = -8'sd3; in_valid = 1; cyc(); in_valid = 0;
    leak = 16'd5; step = 1; cyc(); step = 0;
    chk("neg_leak", macc(0), 0);

    // Priority: clr over step, RST over everything
    do_clr(); zero_d();
    threshold = 16'd10; leak = '0;
    d[0] = 8'sd50; in_valid = 1; cyc(); in_valid = 0;
    clr = 1; step = 1; cyc(); clr = 0; step = 0;
    chk("clr_step_acc", macc(0), 0);
    chk("clr_step_spk", int'(spike_out[0]), 0);
    chk("clr_step_valid", int'(spike_valid), 0);
    d[0] = 8'sd50; in_valid = 1; cyc();
    RST = 1; step = 1; cyc(); RST = 0; step = 0; in_valid = 0;
    chk("rst_step_acc", macc(0), 0);
    chk("rst_step_valid", int'(spike_valid), 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      RST        = ($urandom_range(0, 99) == 0);
      clr        = ($urandom_range(0, 59) == 0);
      clken      = ($urandom_range(0, 7) != 0);
      step       = ($urandom_range(0, 3) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      reset_mode = $urandom_range(0, 1);
      threshold  = ACC_W'($urandom_range(1, 300));
      leak       = ACC_W'($urandom_range(0, 15));
      refrac_len = REFRAC_W'($urandom_range(0, 3));
      for (int i = 0; i < N_CH; i++) d[i] = DATA_W'($urandom_range(0, 255));
      cyc();
    end

    RST = 0; clr = 0; step = 0; in_valid = 0;
    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
